// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
//   - arb_state_e : FSM state encoding (StIdle, StBusy, StResp)
//   - gnt_e       : grant IDs (GNT_I = fetch port, GNT_D = data port)
//   - DEF_*       : default parameter values
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_TIMEOUT_CYC = 255;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   function automatic gnt_e other_port(input gnt_e g);
      return (g == GNT_I) ? GNT_D : GNT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port, shared memory bus and status
// signals of mem_arbiter.
//   master : arbiter view (drives responses, memory bus and status)
//   slave  : environment view (requesters and memory)
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   // Fetch port
   logic              iI_Req;
   logic [ADDR_W-1:0] iI_Addr;
   logic [DATA_W-1:0] oI_Data;
   logic              oI_Rdy;
   // Data port
   logic              iD_Read;
   logic              iD_Write;
   logic [ADDR_W-1:0] iD_Addr;
   logic [DATA_W-1:0] iD_WData;
   logic [BE_W-1:0]   iD_BE;
   logic [DATA_W-1:0] oD_RData;
   logic              oD_Rdy;
   // Shared memory bus
   logic [ADDR_W-1:0] oMem_Addr;
   logic [DATA_W-1:0] oMem_WData;
   logic [BE_W-1:0]   oMem_BE;
   logic              oMem_Read;
   logic              oMem_Write;
   logic [DATA_W-1:0] iMem_RData;
   logic              iMem_Ack;
   // Status
   logic              oBusy;
   logic              oErr;

   modport master (
      input  iI_Req, iI_Addr, iD_Read, iD_Write, iD_Addr, iD_WData, iD_BE,
      input  iMem_RData, iMem_Ack,
      output oI_Data, oI_Rdy, oD_RData, oD_Rdy,
      output oMem_Addr, oMem_WData, oMem_BE, oMem_Read, oMem_Write,
      output oBusy, oErr
   );

   modport slave (
      output iI_Req, iI_Addr, iD_Read, iD_Write, iD_Addr, iD_WData, iD_BE,
      output iMem_RData, iMem_Ack,
      input  oI_Data, oI_Rdy, oD_RData, oD_Rdy,
      input  oMem_Addr, oMem_WData, oMem_BE, oMem_Read, oMem_Write,
      input  oBusy, oErr
   );

endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational 2-way round-robin picker.
//   req_fetch_i / req_data_i : pending requests
//   last_gnt_i               : port granted most recently
//   valid_o                  : at least one request pending
//   gnt_o                    : port to grant (meaningful when valid_o)
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic req_fetch_i,
   input  logic req_data_i,
   input  gnt_e last_gnt_i,
   output logic valid_o,
   output gnt_e gnt_o
);

   always_comb begin
      valid_o = req_fetch_i | req_data_i;
      gnt_o   = GNT_D;
      if (req_fetch_i && req_data_i) begin
         // Contention: the port that was not served last wins.
         gnt_o = other_port(last_gnt_i);
      end else if (req_fetch_i) begin
         gnt_o = GNT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction-fetch port and a
// data port using a three-state FSM (idle / busy / response) and round-robin
// arbitration. Memory bus outputs are registered and held until iMem_Ack.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : mem_arbiter_if.master (fetch port, data port, memory bus, status)
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC busy cycles without ack (read data 0, sticky oErr). Without it the
// arbiter waits forever and oErr is tied low.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic          iClk,
   input logic          iRst,
   mem_arbiter_if.master bus
);

   localparam int unsigned BE_W = DATA_W / 8;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   arb_state_e        state_q, state_d;
   gnt_e              gnt_q, gnt_d;
   gnt_e              last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [DATA_W-1:0] i_data_q, i_data_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
`endif

   logic pick_valid;
   gnt_e pick_gnt;

   mem_arb_rr u_rr (
      .req_fetch_i (bus.iI_Req),
      .req_data_i  (bus.iD_Read | bus.iD_Write),
      .last_gnt_i  (last_gnt_q),
      .valid_o     (pick_valid),
      .gnt_o       (pick_gnt)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_gnt_d  = last_gnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      i_data_d    = i_data_q;
      d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif

      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d    = StBusy;
               gnt_d      = pick_gnt;
               last_gnt_d = pick_gnt;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d      = '0;
`endif
               if (pick_gnt == GNT_I) begin
                  mem_addr_d  = bus.iI_Addr;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
                  mem_read_d  = 1'b1;
                  mem_write_d = 1'b0;
               end else begin
                  // Simultaneous read and write on the data port resolves to the write.
                  mem_addr_d  = bus.iD_Addr;
                  mem_wdata_d = bus.iD_WData;
                  mem_be_d    = bus.iD_BE;
                  mem_write_d = bus.iD_Write;
                  mem_read_d  = ~bus.iD_Write;
               end
            end
         end

         StBusy: begin
            if (bus.iMem_Ack) begin
               state_d     = StResp;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q) begin
                  if (gnt_q == GNT_I) i_data_d  = bus.iMem_RData;
                  else                d_rdata_d = bus.iMem_RData;
               end
`ifdef MEM_ARB_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
               // Last allowed busy cycle without ack: abort and report zero data.
               state_d     = StResp;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               err_d       = 1'b1;
               if (mem_read_q) begin
                  if (gnt_q == GNT_I) i_data_d  = '0;
                  else                d_rdata_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q     <= StIdle;
         gnt_q       <= GNT_I;
         last_gnt_q  <= GNT_I;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_data_q    <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_gnt_q  <= last_gnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         i_data_q    <= i_data_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.oErr = err_q;
`else
   assign bus.oErr = 1'b0;
`endif

   assign bus.oMem_Addr  = mem_addr_q;
   assign bus.oMem_WData = mem_wdata_q;
   assign bus.oMem_BE    = mem_be_q;
   assign bus.oMem_Read  = mem_read_q;
   assign bus.oMem_Write = mem_write_q;
   assign bus.oI_Data    = i_data_q;
   assign bus.oD_RData   = d_rdata_q;
   assign bus.oI_Rdy     = (state_q == StResp) && (gnt_q == GNT_I);
   assign bus.oD_Rdy     = (state_q == StResp) && (gnt_q == GNT_D);
   assign bus.oBusy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (round-robin winner, per-port data registers).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   gnt_e        exp_last;
   logic [31:0] exp_i_data;
   logic [31:0] exp_d_rdata;
   logic        exp_err;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic release_port(input bit gd);
      if (gd) begin
         bus.iD_Read  = 1'b0;
         bus.iD_Write = 1'b0;
      end else begin
         bus.iI_Req = 1'b0;
      end
   endtask

   task automatic model_reset();
      exp_last    = GNT_I;
      exp_i_data  = '0;
      exp_d_rdata = '0;
      exp_err     = 1'b0;
   endtask

   // Called at the negedge after the IDLE sampling edge: checks the bus, acks after
   // dly cycles, checks the response cycle and the following idle cycle.
   task automatic serve(input string tag, input bit gd, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wdata, input logic [3:0] be, input int dly,
                        input bit drop_early);
      logic [31:0] rdata;
      rdata = $urandom;
      check_eq({tag, ".busy"}, 64'(bus.oBusy), 64'd1);
      check_eq({tag, ".rd"}, 64'(bus.oMem_Read), 64'(!wr));
      check_eq({tag, ".wr"}, 64'(bus.oMem_Write), 64'(wr));
      check_eq({tag, ".addr"}, 64'(bus.oMem_Addr), 64'(addr));
      if (wr) begin
         check_eq({tag, ".wdata"}, 64'(bus.oMem_WData), 64'(wdata));
         check_eq({tag, ".be"}, 64'(bus.oMem_BE), 64'(be));
      end
      if (drop_early) release_port(gd);
      for (int k = 0; k < dly; k++) begin
         step();
         check_eq({tag, ".hold"}, 64'({bus.oMem_Read, bus.oMem_Write, bus.oMem_Addr}),
                  64'({!wr, wr, addr}));
         check_eq({tag, ".nordy"}, 64'({bus.oI_Rdy, bus.oD_Rdy}), 64'd0);
      end
      bus.iMem_Ack   = 1'b1;
      bus.iMem_RData = rdata;
      step();
      bus.iMem_Ack   = 1'b0;
      bus.iMem_RData = $urandom;
      if (!wr) begin
         if (gd) exp_d_rdata = rdata;
         else    exp_i_data  = rdata;
      end
      exp_last = gd ? GNT_D : GNT_I;
      check_eq({tag, ".strb_off"}, 64'({bus.oMem_Read, bus.oMem_Write}), 64'd0);
      check_eq({tag, ".i_rdy"}, 64'(bus.oI_Rdy), 64'(!gd));
      check_eq({tag, ".d_rdy"}, 64'(bus.oD_Rdy), 64'(gd));
      check_eq({tag, ".i_data"}, 64'(bus.oI_Data), 64'(exp_i_data));
      check_eq({tag, ".d_rdata"}, 64'(bus.oD_RData), 64'(exp_d_rdata));
      check_eq({tag, ".err"}, 64'(bus.oErr), 64'(exp_err));
      release_port(gd);
      step();
      check_eq({tag, ".idle"}, 64'(bus.oBusy), 64'd0);
      check_eq({tag, ".rdy_off"}, 64'({bus.oI_Rdy, bus.oD_Rdy}), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      step();
      check_eq("rst.strb", 64'({bus.oMem_Read, bus.oMem_Write}), 64'd0);
      check_eq("rst.rdy", 64'({bus.oI_Rdy, bus.oD_Rdy, bus.oBusy, bus.oErr}), 64'd0);
      check_eq("rst.data", 64'({bus.oI_Data, bus.oD_RData}), 64'd0);
      check_eq("rst.addr", 64'(bus.oMem_Addr), 64'd0);
      rst = 1'b0;
      step();
   endtask

   initial begin
      bit          want_i, want_d, first_d;
      int          op;
      logic [31:0] i_addr, d_addr, d_wdata;
      logic [3:0]  d_be;
      bit          d_wr;

      rst            = 1'b1;
      bus.iI_Req     = 1'b0;
      bus.iI_Addr    = '0;
      bus.iD_Read    = 1'b0;
      bus.iD_Write   = 1'b0;
      bus.iD_Addr    = '0;
      bus.iD_WData   = '0;
      bus.iD_BE      = '0;
      bus.iMem_RData = '0;
      bus.iMem_Ack   = 1'b0;
      step();
      do_reset();

      // Fetch only, ack one cycle after strobe
      bus.iI_Req  = 1'b1;
      bus.iI_Addr = 32'h100;
      step();
      serve("fetch", 1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 1, 1'b0);
      check_eq("fetch.word", 64'(bus.oI_Data), 64'(exp_i_data));

      // Simultaneous requests after reset: data port first
      do_reset();
      bus.iD_Read = 1'b1;
      bus.iD_Addr = 32'h2000;
      bus.iI_Req  = 1'b1;
      bus.iI_Addr = 32'h104;
      step();
      serve("both.d", 1'b1, 32'h2000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      step();
      serve("both.i", 1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 2, 1'b0);

      // Read+write conflict resolves to write
      bus.iD_Read  = 1'b1;
      bus.iD_Write = 1'b1;
      bus.iD_Addr  = 32'h3000;
      bus.iD_WData = 32'hCAFEF00D;
      bus.iD_BE    = 4'hF;
      step();
      serve("rw", 1'b1, 32'h3000, 1'b1, 32'hCAFEF00D, 4'hF, 1, 1'b0);

      // Reset two cycles into a fetch, data port waiting too
      bus.iI_Req  = 1'b1;
      bus.iI_Addr = 32'h200;
      step();
      check_eq("abort.strb", 64'(bus.oMem_Read), 64'd1);
      step();
      step();
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("abort.now", 64'({bus.oMem_Read, bus.oMem_Write, bus.oBusy}), 64'd0);
      bus.iD_Read = 1'b1;
      bus.iD_Addr = 32'h4000;
      step();
      check_eq("abort.nordy", 64'({bus.oI_Rdy, bus.oD_Rdy}), 64'd0);
      rst = 1'b0;
      step();
      serve("abort.d", 1'b1, 32'h4000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      step();
      serve("abort.i", 1'b0, 32'h200, 1'b0, 32'h0, 4'h0, 0, 1'b0);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.iMem_Ack = 1'b1;
            step();
            check_eq("rnd.stray_ack", 64'(bus.oBusy), 64'd0);
            bus.iMem_Ack = 1'b0;
         end
         op      = int'($urandom_range(1, 3));
         want_i  = op[0];
         want_d  = op[1];
         i_addr  = $urandom & 32'hFFFF_FFFC;
         d_addr  = $urandom;
         d_wdata = $urandom;
         d_be    = 4'($urandom);
         op      = int'($urandom_range(0, 2));
         d_wr    = (op != 0);
         bus.iI_Req   = want_i;
         bus.iI_Addr  = i_addr;
         bus.iD_Read  = want_d && (op != 1);
         bus.iD_Write = want_d && (op != 0);
         bus.iD_Addr  = d_addr;
         bus.iD_WData = d_wdata;
         bus.iD_BE    = d_be;
         first_d = (want_i && want_d) ? (exp_last == GNT_I) : want_d;
         step();
         if (first_d) serve("rnd.d", 1'b1, d_addr, d_wr, d_wdata, d_be,
                            int'($urandom_range(0, 3)), 1'($urandom));
         else         serve("rnd.i", 1'b0, i_addr, 1'b0, 32'h0, 4'h0,
                            int'($urandom_range(0, 3)), 1'($urandom));
         if (want_i && want_d) begin
            step();
            if (first_d) serve("rnd.i2", 1'b0, i_addr, 1'b0, 32'h0, 4'h0,
                               int'($urandom_range(0, 3)), 1'b0);
            else         serve("rnd.d2", 1'b1, d_addr, d_wr, d_wdata, d_be,
                               int'($urandom_range(0, 3)), 1'b0);
         end
      end

      // Timeout behaviour: fetch that is never acknowledged
      bus.iI_Req  = 1'b1;
      bus.iI_Addr = 32'h500;
      step();
      check_eq("to.strb", 64'(bus.oMem_Read), 64'd1);
`ifdef MEM_ARB_TIMEOUT_EN
      for (int k = 1; k < int'(TO); k++) begin
         step();
         check_eq("to.held", 64'(bus.oMem_Read), 64'd1);
      end
      step();
      exp_i_data = '0;
      exp_err    = 1'b1;
      check_eq("to.drop", 64'(bus.oMem_Read), 64'd0);
      check_eq("to.rdy", 64'({bus.oI_Rdy, bus.oD_Rdy}), 64'b10);
      check_eq("to.data", 64'(bus.oI_Data), 64'(exp_i_data));
      check_eq("to.err", 64'(bus.oErr), 64'd1);
      bus.iI_Req = 1'b0;
      step();
      check_eq("to.idle", 64'(bus.oBusy), 64'd0);
      bus.iD_Read = 1'b1;
      bus.iD_Addr = 32'h600;
      step();
      serve("to.after", 1'b1, 32'h600, 1'b0, 32'h0, 4'h0, 1, 1'b0);
`else
      for (int k = 0; k < 3 * int'(TO); k++) begin
         step();
         check_eq("to.held", 64'(bus.oMem_Read), 64'd1);
         check_eq("to.err", 64'(bus.oErr), 64'd0);
      end
      serve("to.late", 1'b0, 32'h500, 1'b0, 32'h0, 4'h0, 0, 1'b0);
`endif
      do_reset();
      check_eq("final.err", 64'(bus.oErr), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
